// File: rtl/data_sram_responder.sv
// Data-memory slave for the memory stage: one access at a time, response after LATENCY cycles, held until ack.
// Optional macro DATA_SRAM_RANDOM_DELAY_EN adds 0..3 LFSR-chosen extra wait cycles per access.
module data_sram_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_ack,
   output logic        data_ready,
   output logic        data_valid,
   output logic [31:0] read_data
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]            state;
   logic [4:0]            cnt;
   logic                  abort;
   logic [ADDR_WIDTH-1:0] idx;
   logic [3:0]            we;
   logic [31:0]           wdata;
   logic [4:0]            load_cnt;
   logic                  access;
   logic                  aborted;
   logic                  unused_addr_bits;

   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

   assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

`ifdef DATA_SRAM_RANDOM_DELAY_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign load_cnt = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
   assign load_cnt = 5'(LATENCY);
`endif

   assign access  = (state == BUSY) && (cnt == 5'd1);
   // a flush seen in the executing cycle itself also suppresses the response
   assign aborted = abort | ~req_en;

   // Writes commit even when the requester flushed mid-access.
   always_ff @(posedge clk) begin
      if (!rst && access) begin
         for (int k = 0; k < 4; k++) begin
            if (we[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 5'd0;
         abort      <= 1'b0;
         idx        <= '0;
         we         <= 4'd0;
         wdata      <= 32'd0;
         data_ready <= 1'b0;
         data_valid <= 1'b0;
         read_data  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_en) begin
                  idx   <= req_addr[ADDR_WIDTH+1:2];
                  we    <= req_we;
                  wdata <= req_wdata;
                  cnt   <= load_cnt;
                  abort <= 1'b0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 5'd1;
               if (!req_en) abort <= 1'b1;
               if (access) begin
                  if (we == 4'd0) read_data <= mem[idx];
                  if (aborted) begin
                     state <= IDLE;
                  end else begin
                     state      <= RESP;
                     data_ready <= |we;
                     data_valid <= ~|we;
                  end
               end
            end
            RESP: begin
               if (req_ack || !req_en) begin
                  state      <= IDLE;
                  data_ready <= 1'b0;
                  data_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
